// File: rtl/tug_pkg.sv
// Shared types and constants for the tug-of-war referee: state encoding,
// playfield geometry and winner codes.
package tug_pkg;

    typedef enum logic [1:0] {
        SERVE = 2'd0,
        PLAY  = 2'd1,
        WIN   = 2'd2,
        OVER  = 2'd3
    } state_t;

    localparam int NUM_LEDS = 9;
    localparam logic [3:0] CENTER_POS = 4'd4;
    localparam logic [3:0] LAST_POS   = 4'd8;
    localparam logic [3:0] FIRST_POS  = 4'd0;

    localparam logic [1:0] WIN_NONE  = 2'b00;
    localparam logic [1:0] WIN_LEFT  = 2'b10;
    localparam logic [1:0] WIN_RIGHT = 2'b01;

endpackage

// File: rtl/seg7.sv
// Active-low 7-segment decoder for score digits 0..7, segment order {g,f,e,d,c,b,a}.
module seg7 (
    input  logic [2:0] digit,
    output logic [6:0] seg
);

    // Digit to segment pattern lookup
    always_comb begin
        seg = 7'b1111111;
        case (digit)
            3'd0:    seg = 7'b1000000;
            3'd1:    seg = 7'b1111001;
            3'd2:    seg = 7'b0100100;
            3'd3:    seg = 7'b0110000;
            3'd4:    seg = 7'b0011001;
            3'd5:    seg = 7'b0010010;
            3'd6:    seg = 7'b0000010;
            3'd7:    seg = 7'b1111000;
            default: seg = 7'b1111111;
        endcase
    end

endmodule

// File: rtl/tug_referee.sv
// Tug-of-war referee: moves the lit LED on presses, scores rounds, holds the
// win display and stops the match once a player reaches SCORE_MAX.
module tug_referee
    import tug_pkg::*;
#(
    parameter int HOLD_CYCLES = 8,
    parameter int SCORE_MAX   = 7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       press_l,
    input  logic       press_r,
    output logic       play_en,
    output logic [8:0] light,
    output logic [1:0] winner,
    output logic [2:0] score_l,
    output logic [2:0] score_r,
    output logic [6:0] hex_l,
    output logic [6:0] hex_r
);

    localparam logic [2:0] SCORE_LIMIT = 3'(SCORE_MAX);
    localparam logic [7:0] HOLD_LAST   = 8'(HOLD_CYCLES - 1);

    state_t     state_q, state_d;
    logic [3:0] pos_q, pos_d;
    logic [7:0] hold_q, hold_d;
    logic [2:0] score_l_q, score_l_d;
    logic [2:0] score_r_q, score_r_d;
    logic [1:0] winner_q, winner_d;
    logic [2:0] win_score_s;
    logic       only_l_s, only_r_s;

    assign only_l_s = press_l & ~press_r;
    assign only_r_s = press_r & ~press_l;

    // Next state, position, hold count, scores and winner
    always_comb begin
        state_d   = state_q;
        pos_d     = pos_q;
        hold_d    = hold_q;
        score_l_d = score_l_q;
        score_r_d = score_r_q;
        winner_d  = winner_q;
        win_score_s = (winner_q == WIN_LEFT) ? score_l_q : score_r_q;
        case (state_q)
            SERVE: begin
                pos_d    = CENTER_POS;
                winner_d = WIN_NONE;
                state_d  = PLAY;
            end
            PLAY: begin
                if (only_l_s) begin
                    if (pos_q == LAST_POS) begin
                        score_l_d = (score_l_q < SCORE_LIMIT) ? score_l_q + 3'd1 : score_l_q;
                        winner_d  = WIN_LEFT;
                        hold_d    = 8'd0;
                        state_d   = WIN;
                    end else begin
                        pos_d = pos_q + 4'd1;
                    end
                end else if (only_r_s) begin
                    if (pos_q == FIRST_POS) begin
                        score_r_d = (score_r_q < SCORE_LIMIT) ? score_r_q + 3'd1 : score_r_q;
                        winner_d  = WIN_RIGHT;
                        hold_d    = 8'd0;
                        state_d   = WIN;
                    end else begin
                        pos_d = pos_q - 4'd1;
                    end
                end else begin
                    pos_d = pos_q;
                end
            end
            WIN: begin
                // The winning score was registered on entry, so it is final here
                if (hold_q == HOLD_LAST) begin
                    hold_d = 8'd0;
                    if (win_score_s == SCORE_LIMIT) begin
                        state_d = OVER;
                    end else begin
                        state_d  = SERVE;
                        pos_d    = CENTER_POS;
                        winner_d = WIN_NONE;
                    end
                end else begin
                    hold_d = hold_q + 8'd1;
                end
            end
            OVER: begin
                state_d = OVER;
            end
            default: begin
                state_d = SERVE;
                pos_d   = CENTER_POS;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= SERVE;
            pos_q     <= CENTER_POS;
            hold_q    <= 8'd0;
            score_l_q <= 3'd0;
            score_r_q <= 3'd0;
            winner_q  <= WIN_NONE;
        end else begin
            state_q   <= state_d;
            pos_q     <= pos_d;
            hold_q    <= hold_d;
            score_l_q <= score_l_d;
            score_r_q <= score_r_d;
            winner_q  <= winner_d;
        end
    end

    assign play_en = (state_q == PLAY);
    assign light   = 9'b000000001 << pos_q;
    assign winner  = winner_q;
    assign score_l = score_l_q;
    assign score_r = score_r_q;

    seg7 u_seg7_l (.digit(score_l_q), .seg(hex_l));
    seg7 u_seg7_r (.digit(score_r_q), .seg(hex_r));

endmodule

// File: tb/tb_tug_referee.sv
// Directed self-checking bench for tug_referee with default parameters.
module tb_tug_referee;
    import tug_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       press_l = 1'b0;
    logic       press_r = 1'b0;
    logic       play_en;
    logic [8:0] light;
    logic [1:0] winner;
    logic [2:0] score_l, score_r;
    logic [6:0] hex_l, hex_r;

    int pass_cnt = 0;
    int total_cnt = 0;

    tug_referee #(.HOLD_CYCLES(8), .SCORE_MAX(7)) dut (
        .clk(clk), .reset(reset), .press_l(press_l), .press_r(press_r),
        .play_en(play_en), .light(light), .winner(winner),
        .score_l(score_l), .score_r(score_r), .hex_l(hex_l), .hex_r(hex_r)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    function automatic logic [6:0] hex_of(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            default: return 7'b1111111;
        endcase
    endfunction

    // Advance one clock; play_en must mirror the PLAY state every cycle
    task automatic tick();
        @(posedge clk);
        #1;
        total_cnt++;
        if (play_en !== (dut.state_q == PLAY)) begin
            $display("FAIL play_en_vs_state: play_en=%b state=%0d", play_en, dut.state_q);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        total_cnt++;
        if ({play_en, light, winner, score_l, score_r, hex_l, hex_r} !==
            {1'b0, 9'b000010000, 2'b00, 3'd0, 3'd0, 7'b1000000, 7'b1000000}) begin
            $display("FAIL reset_state: play_en=%b light=%b winner=%b sl=%0d sr=%0d hl=%b hr=%b",
                     play_en, light, winner, score_l, score_r, hex_l, hex_r);
        end else pass_cnt++;
        press_l = 1'b1;
        tick();
        press_l = 1'b0;
        total_cnt++;
        if ({play_en, light} !== {1'b1, 9'b000010000}) begin
            $display("FAIL serve_to_play: play_en=%b light=%b, want 1 000010000", play_en, light);
        end else pass_cnt++;
    endtask

    task automatic test_left_win();
        press_l = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        total_cnt++;
        if (light !== 9'b100000000) begin
            $display("FAIL left_edge: light=%b want 100000000", light);
        end else pass_cnt++;
        tick();
        press_l = 1'b0;
        total_cnt++;
        if ({score_l, winner, play_en, light, hex_l} !==
            {3'd1, 2'b10, 1'b0, 9'b100000000, 7'b1111001}) begin
            $display("FAIL left_score: sl=%0d winner=%b play_en=%b light=%b hl=%b",
                     score_l, winner, play_en, light, hex_l);
        end else pass_cnt++;
        press_r = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        press_r = 1'b0;
        total_cnt++;
        if ({play_en, winner, light, score_l, score_r} !== {1'b0, 2'b10, 9'b100000000, 3'd1, 3'd0}) begin
            $display("FAIL win_hold: play_en=%b winner=%b light=%b sl=%0d sr=%0d",
                     play_en, winner, light, score_l, score_r);
        end else pass_cnt++;
        tick();
        total_cnt++;
        if ({play_en, winner, light} !== {1'b0, 2'b00, 9'b000010000}) begin
            $display("FAIL win_exit_serve: play_en=%b winner=%b light=%b", play_en, winner, light);
        end else pass_cnt++;
        tick();
        total_cnt++;
        if ({play_en, winner, light} !== {1'b1, 2'b00, 9'b000010000}) begin
            $display("FAIL next_round_play: play_en=%b winner=%b light=%b", play_en, winner, light);
        end else pass_cnt++;
    endtask

    task automatic test_both_press();
        press_l = 1'b1;
        press_r = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        press_l = 1'b0;
        total_cnt++;
        if (light !== 9'b000010000) begin
            $display("FAIL both_press: light=%b want 000010000", light);
        end else pass_cnt++;
        tick();
        press_r = 1'b0;
        total_cnt++;
        if (light !== 9'b000001000) begin
            $display("FAIL right_step: light=%b want 000001000", light);
        end else pass_cnt++;
    endtask

    task automatic right_round(input int k);
        int guard;
        guard = 0;
        press_r = 1'b1;
        while (play_en === 1'b1 && guard < 20) begin
            tick();
            guard++;
        end
        press_r = 1'b0;
        total_cnt++;
        if ({play_en, score_r, winner, light, hex_r} !== {1'b0, 3'(k), 2'b01, 9'b000000001, hex_of(k)}) begin
            $display("FAIL right_win_%0d: play_en=%b sr=%0d winner=%b light=%b hr=%b want sr=%0d",
                     k, play_en, score_r, winner, light, hex_r, k);
        end else pass_cnt++;
        press_l = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        press_l = 1'b0;
        total_cnt++;
        if ({score_l, score_r, light, winner} !== {3'd1, 3'(k), 9'b000000001, 2'b01}) begin
            $display("FAIL win_ignores_press_%0d: sl=%0d sr=%0d light=%b winner=%b",
                     k, score_l, score_r, light, winner);
        end else pass_cnt++;
        tick();
        if (k < 7) begin
            total_cnt++;
            if ({play_en, winner, light} !== {1'b0, 2'b00, 9'b000010000}) begin
                $display("FAIL round_%0d_serve: play_en=%b winner=%b light=%b", k, play_en, winner, light);
            end else pass_cnt++;
            tick();
        end else begin
            total_cnt++;
            if ({dut.state_q == OVER, play_en, winner} !== {1'b1, 1'b0, 2'b01}) begin
                $display("FAIL match_over: state=%0d play_en=%b winner=%b", dut.state_q, play_en, winner);
            end else pass_cnt++;
        end
    endtask

    task automatic test_right_match();
        for (int k = 1; k <= 7; k++) right_round(k);
        for (int i = 0; i < 20; i++) begin
            press_l = (i % 2 == 0);
            press_r = (i % 2 == 1);
            tick();
            total_cnt++;
            if ({play_en, light, winner, score_l, score_r, hex_l, hex_r} !==
                {1'b0, 9'b000000001, 2'b01, 3'd1, 3'd7, 7'b1111001, 7'b1111000}) begin
                $display("FAIL over_absorbing_%0d: play_en=%b light=%b winner=%b sl=%0d sr=%0d",
                         i, play_en, light, winner, score_l, score_r);
            end else pass_cnt++;
        end
        press_l = 1'b0;
        press_r = 1'b0;
    endtask

    task automatic left_to_win();
        int guard;
        guard = 0;
        press_l = 1'b1;
        while (play_en === 1'b1 && guard < 20) begin
            tick();
            guard++;
        end
        press_l = 1'b0;
    endtask

    task automatic test_reset_mid_win();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        left_to_win();
        for (int i = 0; i < 9; i++) tick();
        left_to_win();
        tick();
        tick();
        total_cnt++;
        if ({play_en, score_l, winner} !== {1'b0, 3'd2, 2'b10}) begin
            $display("FAIL pre_reset_win: play_en=%b sl=%0d winner=%b", play_en, score_l, winner);
        end else pass_cnt++;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total_cnt++;
        if ({score_l, score_r, winner, light, play_en} !== {3'd0, 3'd0, 2'b00, 9'b000010000, 1'b0}) begin
            $display("FAIL reset_mid_win: sl=%0d sr=%0d winner=%b light=%b play_en=%b",
                     score_l, score_r, winner, light, play_en);
        end else pass_cnt++;
        tick();
        total_cnt++;
        if (play_en !== 1'b1) begin
            $display("FAIL play_after_reset: play_en=%b want 1", play_en);
        end else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_left_win();
        test_both_press();
        test_right_match();
        test_reset_mid_win();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
